async_fifo: RTL and testbench

//  Dual-clock FIFO crossing data from a write-clock domain to a read-clock domain.

---
 rtl/async_fifo_pkg.sv | 22 ++
 rtl/async_fifo_sync.sv | 25 ++
 rtl/async_fifo.sv | 107 ++++++++++
 tb/tb_async_fifo.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: binary <-> Gray conversion.
// Callers cast to and from GrayMaxW bits so one pair of functions
// covers any pointer width up to GrayMaxW.
package async_fifo_pkg;

  localparam int unsigned GrayMaxW = 32;

  function automatic logic [GrayMaxW-1:0] bin2gray(input logic [GrayMaxW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [GrayMaxW-1:0] gray2bin(input logic [GrayMaxW-1:0] g);
    logic [GrayMaxW-1:0] b;
    b[GrayMaxW-1] = g[GrayMaxW-1];
    for (int i = GrayMaxW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_sync.sv
// N-bit two-flop synchronizer with asynchronous active-low reset.
// Only Gray-coded values are passed through, so at most one bit changes at a time.
module async_fifo_sync #(
  parameter int unsigned Width = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/async_fifo.sv
// Dual-clock FIFO: write_clk producer side, read_clk consumer side.
// Gray pointers cross domains through two-flop synchronizers, so the
// flags are conservative: full/empty release a few cycles late.
// Build option: define ASYNC_FIFO_FWFT_EN for first-word-fall-through
// (read_data shows the head word combinationally; read_en pops it).
module async_fifo #(
  parameter int unsigned RAM_WIDTH = 8,
  parameter int unsigned RAM_DEPTH = 256
) (
  input  logic                 write_clk,
  input  logic                 read_clk,
  input  logic                 rst_n,
  input  logic                 write_en,
  input  logic [RAM_WIDTH-1:0] write_data,
  input  logic                 read_en,
  output logic [RAM_WIDTH-1:0] read_data,
  output logic                 fifo_full,
  output logic                 fifo_empty
);

  import async_fifo_pkg::*;

  localparam int unsigned AW = $clog2(RAM_DEPTH);
  // Extra MSB distinguishes full from empty when the index bits match.
  localparam int unsigned PW = AW + 1;

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  logic [PW-1:0] wbin, wbin_next, wgray, wgray_next, rgray_sync;
  logic [PW-1:0] rbin, rbin_next, rgray, rgray_next, wgray_sync;
  logic          write_fire, read_fire;

  assign write_fire = write_en && !fifo_full;
  assign read_fire  = read_en && !fifo_empty;

  assign wbin_next  = wbin + PW'(write_fire);
  assign wgray_next = PW'(bin2gray(GrayMaxW'(wbin_next)));
  assign rbin_next  = rbin + PW'(read_fire);
  assign rgray_next = PW'(bin2gray(GrayMaxW'(rbin_next)));

  // Write pointer and full flag; full compares against the read pointer
  // with its top two Gray bits inverted (same index, opposite lap).
  always_ff @(posedge write_clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin      <= '0;
      wgray     <= '0;
      fifo_full <= 1'b0;
    end else begin
      wbin      <= wbin_next;
      wgray     <= wgray_next;
      fifo_full <= (wgray_next == {~rgray_sync[AW:AW-1], rgray_sync[AW-2:0]});
    end
  end

  // Storage is written only from the write domain and never reset.
  always_ff @(posedge write_clk) begin
    if (write_fire) begin
      mem[wbin[AW-1:0]] <= write_data;
    end
  end

  // Read pointer and empty flag, registered from the next pointer value.
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin       <= '0;
      rgray      <= '0;
      fifo_empty <= 1'b1;
    end else begin
      rbin       <= rbin_next;
      rgray      <= rgray_next;
      fifo_empty <= (rgray_next == wgray_sync);
    end
  end

`ifdef ASYNC_FIFO_FWFT_EN
  // Head word falls through; only meaningful while not empty.
  assign read_data = mem[rbin[AW-1:0]];
`else
  // Registered read port; holds its last value when no read is accepted.
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data <= '0;
    end else if (read_fire) begin
      read_data <= mem[rbin[AW-1:0]];
    end
  end
`endif

  async_fifo_sync #(
    .Width (PW)
  ) u_wgray_sync (
    .clk   (read_clk),
    .rst_n (rst_n),
    .d     (wgray),
    .q     (wgray_sync)
  );

  async_fifo_sync #(
    .Width (PW)
  ) u_rgray_sync (
    .clk   (write_clk),
    .rst_n (rst_n),
    .d     (rgray),
    .q     (rgray_sync)
  );

endmodule

// File: tb/tb_async_fifo.sv
// Self-checking bench for async_fifo (standard registered-read build).
// Accepted writes are pushed to a scoreboard queue; each accepted read pops
// the expected word, which is compared against read_data one read_clk later.
`timescale 1ns/1ps
module tb_async_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 256;

  logic             write_clk = 1'b0;
  logic             read_clk  = 1'b0;
  logic             rst_n     = 1'b0;
  logic             write_en  = 1'b0;
  logic [WIDTH-1:0] write_data = '0;
  logic             read_en   = 1'b0;
  logic [WIDTH-1:0] read_data;
  logic             fifo_full;
  logic             fifo_empty;

  logic [WIDTH-1:0] sb [$];
  logic [WIDTH-1:0] src = '0;
  logic [WIDTH-1:0] rd_exp = '0;
  bit               rd_pending = 1'b0;
  bit               wr_started = 1'b0;
  bit               rd_started = 1'b0;
  int               n_wr = 0;
  int               n_rd = 0;
  int               n_cmp = 0;
  int               n_bad = 0;

  async_fifo #(
    .RAM_WIDTH (WIDTH),
    .RAM_DEPTH (DEPTH)
  ) dut (
    .write_clk  (write_clk),
    .read_clk   (read_clk),
    .rst_n      (rst_n),
    .write_en   (write_en),
    .write_data (write_data),
    .read_en    (read_en),
    .read_data  (read_data),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty)
  );

  // Edges chosen so the two clocks never share an edge time.
  always #10 write_clk = ~write_clk;
  initial begin
    #5;
    forever #30 read_clk = ~read_clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, n_wr=%0d n_rd=%0d", n_wr, n_rd);
    $fatal(1);
  end

  // One write_clk cycle: drive at negedge, record the word if the coming edge accepts it.
  task automatic wr_cycle(input bit en);
    @(negedge write_clk);
    write_en   = en;
    write_data = src;
    if (en) begin
      if (!fifo_full) begin
        sb.push_back(src);
        n_wr++;
        wr_started = 1'b1;
        n_cmp++;
        if (sb.size() > DEPTH) begin
          n_bad++;
          $display("FAIL overflow: occupancy %0d exceeds required max %0d", sb.size(), DEPTH);
        end
      end
      src++;
    end
  endtask

  // One read_clk cycle: check the previous pop, then drive read_en for the coming edge.
  task automatic rd_cycle(input bit en);
    @(negedge read_clk);
    if (rd_pending) begin
      n_cmp++;
      if (read_data !== rd_exp) begin
        n_bad++;
        $display("FAIL read_data order: got %h, required %h", read_data, rd_exp);
      end
      rd_pending = 1'b0;
    end
    read_en = en;
    if (en && !fifo_empty) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL underflow: fifo_empty=0 got, required 1 (no words outstanding)");
      end else begin
        rd_exp     = sb.pop_front();
        rd_pending = 1'b1;
        n_rd++;
        rd_started = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    #100;
    n_cmp++;
    if (fifo_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL reset empty: got %b, required 1", fifo_empty);
    end
    n_cmp++;
    if (fifo_full !== 1'b0) begin
      n_bad++;
      $display("FAIL reset full: got %b, required 0", fifo_full);
    end
    n_cmp++;
    if (read_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset read_data: got %h, required 00", read_data);
    end
    #100;
    rst_n = 1'b1;
    repeat (3) @(negedge write_clk);
  endtask

  task automatic test_fill();
    n_wr = 0;
    wr_started = 1'b0;
    fork
      begin
        bit full_checked = 1'b0;
        for (int i = 0; i < 1000; i++) begin
          wr_cycle(1'b1);
          if (n_wr == DEPTH && !full_checked) begin
            full_checked = 1'b1;
            @(posedge write_clk);
            #1;
            n_cmp++;
            if (fifo_full !== 1'b1) begin
              n_bad++;
              $display("FAIL fill full after last write: got %b, required 1", fifo_full);
            end
          end
        end
        wr_cycle(1'b0);
      end
      begin
        bit seen = 1'b0;
        for (int k = 0; k < 2000 && !wr_started; k++) #1;
        @(posedge write_clk);
        for (int k = 0; k < 3 && !seen; k++) begin
          @(posedge read_clk);
          #1;
          seen = !fifo_empty;
        end
        n_cmp++;
        if (fifo_empty !== 1'b0) begin
          n_bad++;
          $display("FAIL fill empty release: got %b after 3 read_clk, required 0", fifo_empty);
        end
      end
    join
    n_cmp++;
    if (n_wr != DEPTH) begin
      n_bad++;
      $display("FAIL fill accepted count: got %0d, required %0d", n_wr, DEPTH);
    end
    n_cmp++;
    if (fifo_full !== 1'b1) begin
      n_bad++;
      $display("FAIL fill full held: got %b, required 1", fifo_full);
    end
  endtask

  task automatic test_drain();
    n_rd = 0;
    rd_started = 1'b0;
    fork
      begin
        for (int i = 0; i < 334; i++) rd_cycle(1'b1);
        rd_cycle(1'b0);
      end
      begin
        bit cleared = 1'b0;
        for (int k = 0; k < 2000 && !rd_started; k++) #1;
        @(posedge read_clk);
        for (int k = 0; k < 3 && !cleared; k++) begin
          @(posedge write_clk);
          #1;
          cleared = !fifo_full;
        end
        n_cmp++;
        if (fifo_full !== 1'b0) begin
          n_bad++;
          $display("FAIL drain full release: got %b after 3 write_clk, required 0", fifo_full);
        end
      end
    join
    n_cmp++;
    if (n_rd != DEPTH) begin
      n_bad++;
      $display("FAIL drain read count: got %0d, required %0d", n_rd, DEPTH);
    end
    n_cmp++;
    if (fifo_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL drain empty: got %b, required 1", fifo_empty);
    end
    n_cmp++;
    if (read_data !== 8'hFF) begin
      n_bad++;
      $display("FAIL drain last word held: got %h, required ff", read_data);
    end
  endtask

  task automatic test_underflow();
    logic [WIDTH-1:0] marker;
    for (int i = 0; i < 6; i++) rd_cycle(1'b1);
    rd_cycle(1'b0);
    n_cmp++;
    if (read_data !== 8'hFF) begin
      n_bad++;
      $display("FAIL underflow read_data: got %h, required ff", read_data);
    end
    n_cmp++;
    if (fifo_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL underflow empty: got %b, required 1", fifo_empty);
    end
    // An unmoved read pointer means the next single write is the next word read.
    marker = src;
    n_rd = 0;
    wr_cycle(1'b1);
    wr_cycle(1'b0);
    for (int i = 0; i < 12 && n_rd == 0; i++) rd_cycle(1'b1);
    rd_cycle(1'b0);
    n_cmp++;
    if (n_rd != 1) begin
      n_bad++;
      $display("FAIL underflow pointer: words read got %0d, required 1 (word %h)", n_rd, marker);
    end
  endtask

  task automatic test_wrap_concurrent();
    n_wr = 0;
    n_rd = 0;
    fork
      begin
        for (int i = 0; i < 20000 && n_wr < 600; i++) wr_cycle(1'($urandom_range(0, 1)));
        wr_cycle(1'b0);
      end
      begin
        for (int i = 0; i < 8000 && n_rd < 600; i++) rd_cycle(1'($urandom_range(0, 1)));
        rd_cycle(1'b0);
      end
    join
    n_cmp++;
    if (n_rd != 600) begin
      n_bad++;
      $display("FAIL wrap read count: got %0d, required 600", n_rd);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL wrap leftover: got %0d words, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] marker;
    for (int i = 0; i < 100; i++) wr_cycle(1'b1);
    wr_cycle(1'b0);
    repeat (4) rd_cycle(1'b0);
    n_cmp++;
    if (fifo_empty !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset pre empty: got %b, required 0", fifo_empty);
    end
    @(negedge write_clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (fifo_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset empty: got %b, required 1", fifo_empty);
    end
    n_cmp++;
    if (read_data !== 8'h00) begin
      n_bad++;
      $display("FAIL midreset read_data: got %h, required 00", read_data);
    end
    sb.delete();
    rd_pending = 1'b0;
    repeat (3) @(negedge write_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge write_clk);
    marker = src;
    n_rd = 0;
    wr_cycle(1'b1);
    wr_cycle(1'b0);
    for (int i = 0; i < 12 && n_rd == 0; i++) rd_cycle(1'b1);
    rd_cycle(1'b0);
    n_cmp++;
    if (n_rd != 1) begin
      n_bad++;
      $display("FAIL midreset next word: words read got %0d, required 1 (word %h)", n_rd, marker);
    end
    n_cmp++;
    if (fifo_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset final empty: got %b, required 1", fifo_empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_underflow();
    test_wrap_concurrent();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
